// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps all 2**N_IN input vectors through a function unit,
// captures its truth table and compares it against a latched golden table.
module tt_sweep_ctrl #(
  parameter int N_IN = 3,
  parameter int LAT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      fu_in,
  input  logic                 fu_y,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 match,
  output logic [N_IN-1:0]      err_idx
);
  localparam int W = 2**N_IN;
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;
  state_t          r_state;
  logic [W-1:0]    r_exp, r_acc, w_acc_nxt, w_diff;
  logic [N_IN-1:0] r_cap, w_err;
  logic            w_drv_v, w_cap_v, w_last_drv, w_last_cap;
  assign w_drv_v    = r_state == DRIVE;
  assign w_last_drv = w_drv_v && fu_in == '1;
  assign w_last_cap = w_cap_v && r_cap == '1;
  // Valid delay line aligns each capture with the unit's LAT-cycle latency.
  generate
    if (LAT == 0) begin : g_nolat
      assign w_cap_v = w_drv_v;
    end else begin : g_lat
      logic [LAT-1:0] r_vdl;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_vdl <= '0;
        else begin
          r_vdl[0] <= w_drv_v;
          for (int i = 1; i < LAT; i++) r_vdl[i] <= r_vdl[i-1];
        end
      assign w_cap_v = r_vdl[LAT-1];
    end
  endgenerate
  always_comb begin
    w_acc_nxt = r_acc;
    if (w_cap_v) w_acc_nxt[r_cap] = fu_y;
  end
  assign w_diff = w_acc_nxt ^ r_exp;
  always_comb begin
    w_err = '0;
    for (int i = W-1; i >= 0; i--) if (w_diff[i]) w_err = N_IN'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_exp     <= '0;
      r_acc     <= '0;
      r_cap     <= '0;
      fu_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      match     <= 1'b0;
      err_idx   <= '0;
    end else begin
      done  <= 1'b0;
      r_acc <= w_acc_nxt;
      if (w_cap_v) r_cap <= r_cap + 1'b1;
      case (r_state)
        IDLE:
          if (start) begin
            r_state <= DRIVE;
            r_exp   <= expected;
            r_acc   <= '0;
            r_cap   <= '0;
            fu_in   <= '0;
            busy    <= 1'b1;
          end
        DRIVE: begin
          fu_in <= w_last_drv ? '0 : fu_in + 1'b1;
          if (w_last_drv) r_state <= DRAIN;
        end
        DRAIN: r_state <= DRAIN;
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
      // The final capture (in DRIVE when LAT=0) completes the sweep.
      if (w_last_cap) begin
        r_state   <= DONE;
        done      <= 1'b1;
        table_out <= w_acc_nxt;
        match     <= w_diff == '0;
        err_idx   <= w_err;
      end
    end
endmodule
